demod_ctrl: RTL and testbench
=============================

DEMOD_CTRL -- requirements
Module: demod_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1: clock, all state on rising edge.
REQ-002 SHALL have port N_Rst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port Valid_Data, input, 1: In_Mod_Data chip valid this cycle.
REQ-004 SHALL have port Correlated_Bit, input, 1: datapath XNOR of delayed reference chip and current chip.
REQ-005 SHALL have port Spread_Factor, input, 5: chips per half-bit, one of 2/4/8/16.
REQ-006 SHALL have port Out_Ack, input, 1: consumer accepted Out_Data.
REQ-007 SHALL have port Frame_Abort, input, 1: synchronous frame discard.
REQ-008 SHALL have port Chip_Ready, output, 1: controller accepts a chip this cycle.
REQ-009 SHALL have ports Var_Del_Reg_Addr (output, 4), Var_Del_Reg_Load (output, 1) and Var_Del_Reg_Re (output, 1): delay register controls.
REQ-010 SHALL have ports Ones_Count_Inc, Zeros_Count_Inc and Ones_Zeros_Count_Clr, each output, 1: accumulator controls.
REQ-011 SHALL have ports STP_Out_Reg_Load (output, 1), STP_Out_Reg_Addr (output, 5) and STP_Out_Reg_Re (output, 1): output register controls.
REQ-012 SHALL have port Out_Valid, output, 1: Out_Data holds a complete frame.

Function
REQ-013 SHALL use states IDLE, REF, DATA, WRITE, DONE, with a 4-bit chip counter chip_cnt, a 5-bit bit index bit_idx and a 5-bit latched spread factor sf.
REQ-014 SHALL define a chip as accepted when Valid_Data and Chip_Ready are both high; Valid_Data with Chip_Ready low SHALL be ignored.
REQ-015 SHALL drive Chip_Ready high in IDLE, REF and DATA, and low in WRITE and DONE.
REQ-016 In IDLE, SHALL drive Var_Del_Reg_Addr = 0.
REQ-017 On an accepted chip in IDLE, SHALL assert Var_Del_Reg_Load, latch sf from Spread_Factor, set chip_cnt = 1 and go to REF.
REQ-018 In REF, SHALL drive Var_Del_Reg_Addr = chip_cnt, assert Var_Del_Reg_Load on an accepted chip and increment chip_cnt.
REQ-019 In REF, when chip_cnt == sf-1 and a chip is accepted, SHALL clear chip_cnt and go to DATA.
REQ-020 In DATA, SHALL hold Var_Del_Reg_Re high and drive Var_Del_Reg_Addr = chip_cnt.
REQ-021 On an accepted chip in DATA, SHALL assert Ones_Count_Inc if Correlated_Bit is 1, otherwise Zeros_Count_Inc, combinationally in the same cycle; never both.
REQ-022 In DATA, when chip_cnt == sf-1 and a chip is accepted, SHALL go to WRITE.
REQ-023 WRITE SHALL last exactly one cycle, asserting STP_Out_Reg_Load with STP_Out_Reg_Addr = bit_idx and asserting Ones_Zeros_Count_Clr in the same cycle.
REQ-024 Leaving WRITE, SHALL go to DONE if bit_idx == (32/sf)-1; otherwise increment bit_idx, clear chip_cnt and go to REF.
REQ-025 SHALL produce 16, 8, 4 or 2 bits per frame for sf 2, 4, 8 or 16 respectively, i.e. 64 chips per frame.
REQ-026 In DONE, SHALL hold STP_Out_Reg_Re and Out_Valid high until Out_Ack, then clear bit_idx and go to IDLE.
REQ-027 Out_Ack outside DONE SHALL have no effect.
REQ-028 Latency: Out_Valid SHALL rise 2 cycles after acceptance of the frame's last chip.
REQ-029 Frame_Abort in any state SHALL force IDLE on the next edge and clear chip_cnt and bit_idx.
REQ-030 During a Frame_Abort cycle, SHALL assert Ones_Zeros_Count_Clr and suppress all other outputs (all low except Ones_Zeros_Count_Clr); this takes priority over every other event.
REQ-031 Changes of Spread_Factor after IDLE SHALL have no effect until the next frame.
REQ-032 Any Spread_Factor value other than 2/4/8/16 sampled in IDLE SHALL be latched as 16.

Reset
REQ-033 While N_Rst is low, SHALL hold state in IDLE with chip_cnt = 0, bit_idx = 0 and sf = 16.
REQ-034 After reset, all outputs SHALL be low except Chip_Ready = 1.
REQ-035 Reset mid-frame SHALL discard the partial frame; datapath registers are reset by the same N_Rst.

Structure
REQ-036 Package dcsk_pkg SHALL hold the state enum demod_state_t, CHIPS_PER_FRAME = 64, STP_WIDTH = 32 and VDR_DEPTH = 16.
REQ-037 SHALL be a single module with no sub-modules; next-state/output logic SHALL be combinational and state/counters registered.

Verification
REQ-038 sf=4, chips ref 1010, data 1010, back-to-back valid -> four Ones_Count_Inc; WRITE at cycle 9 with addr 0; STP bit0 = 1.
REQ-039 sf=2, full 64-chip frame with data chips inverted -> Out_Valid 2 cycles after the last chip; Out_Data[15:0] = 0x0000.
REQ-040 sf=16, Valid_Data high during WRITE -> chip ignored, Chip_Ready = 0 that cycle, counts unchanged.
REQ-041 Frame_Abort in DATA at chip 3 of sf=8 -> IDLE next cycle, Clr pulse, next frame starts at bit_idx 0.
REQ-042 DONE held 5 cycles without Out_Ack -> Out_Valid stays 1, chips ignored; Out_Ack -> IDLE next cycle.
REQ-043 N_Rst asserted mid-REF -> IDLE immediately (asynchronous), Chip_Ready = 1, all other outputs 0.

Source files
------------

// File: rtl/dcsk_pkg.sv
// Shared types, constants and helpers for the DCSK demodulator controller.
package dcsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REF,
        DATA,
        WRITE,
        DONE
    } demod_state_t;

    localparam int CHIPS_PER_FRAME = 64;
    localparam int STP_WIDTH       = 32;
    localparam int VDR_DEPTH       = 16;

    // Unsupported spread factors fall back to the widest setting.
    function automatic logic [4:0] sanitize_sf(input logic [4:0] raw);
        case (raw)
            5'd2, 5'd4, 5'd8, 5'd16: sanitize_sf = raw;
            default:                 sanitize_sf = 5'd16;
        endcase
    endfunction

    // Index of the final bit in a frame, i.e. STP_WIDTH/sf - 1.
    function automatic logic [4:0] last_bit(input logic [4:0] sf);
        case (sf)
            5'd2:    last_bit = 5'd15;
            5'd4:    last_bit = 5'd7;
            5'd8:    last_bit = 5'd3;
            default: last_bit = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/demod_ctrl.sv
// DCSK demodulator controller: sequences reference/data chips per bit and
// hands each decided bit to the output shift register.
module demod_ctrl (
    input  logic       Clk,
    input  logic       N_Rst,
    input  logic       Valid_Data,
    input  logic       Correlated_Bit,
    input  logic [4:0] Spread_Factor,
    input  logic       Out_Ack,
    input  logic       Frame_Abort,
    output logic       Chip_Ready,
    output logic [3:0] Var_Del_Reg_Addr,
    output logic       Var_Del_Reg_Load,
    output logic       Var_Del_Reg_Re,
    output logic       Ones_Count_Inc,
    output logic       Zeros_Count_Inc,
    output logic       Ones_Zeros_Count_Clr,
    output logic       STP_Out_Reg_Load,
    output logic [4:0] STP_Out_Reg_Addr,
    output logic       STP_Out_Reg_Re,
    output logic       Out_Valid
);
    import dcsk_pkg::*;

    demod_state_t state, state_next;
    logic [3:0]   chip_cnt, chip_cnt_next;
    logic [4:0]   bit_idx, bit_idx_next;
    logic [4:0]   sf, sf_next;
    logic         accept;
    logic         last_chip;

    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            state    <= IDLE;
            chip_cnt <= '0;
            bit_idx  <= '0;
            sf       <= 5'd16;
        end else begin
            state    <= state_next;
            chip_cnt <= chip_cnt_next;
            bit_idx  <= bit_idx_next;
            sf       <= sf_next;
        end
    end

    always_comb begin
        state_next           = state;
        chip_cnt_next        = chip_cnt;
        bit_idx_next         = bit_idx;
        sf_next              = sf;
        Chip_Ready           = 1'b0;
        Var_Del_Reg_Addr     = '0;
        Var_Del_Reg_Load     = 1'b0;
        Var_Del_Reg_Re       = 1'b0;
        Ones_Count_Inc       = 1'b0;
        Zeros_Count_Inc      = 1'b0;
        Ones_Zeros_Count_Clr = 1'b0;
        STP_Out_Reg_Load     = 1'b0;
        STP_Out_Reg_Addr     = '0;
        STP_Out_Reg_Re       = 1'b0;
        Out_Valid            = 1'b0;
        accept               = 1'b0;
        last_chip            = (chip_cnt == 4'(sf - 5'd1));

        // An abort wins over everything and also flushes the accumulators.
        if (Frame_Abort) begin
            Ones_Zeros_Count_Clr = 1'b1;
            state_next           = IDLE;
            chip_cnt_next        = '0;
            bit_idx_next         = '0;
        end else begin
            Chip_Ready = (state == IDLE) || (state == REF) || (state == DATA);
            accept     = Valid_Data && Chip_Ready;
            case (state)
                IDLE: begin
                    if (accept) begin
                        Var_Del_Reg_Load = 1'b1;
                        sf_next          = sanitize_sf(Spread_Factor);
                        chip_cnt_next    = 4'd1;
                        state_next       = REF;
                    end
                end
                REF: begin
                    Var_Del_Reg_Addr = chip_cnt;
                    if (accept) begin
                        Var_Del_Reg_Load = 1'b1;
                        if (last_chip) begin
                            chip_cnt_next = '0;
                            state_next    = DATA;
                        end else begin
                            chip_cnt_next = chip_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    Var_Del_Reg_Re   = 1'b1;
                    Var_Del_Reg_Addr = chip_cnt;
                    if (accept) begin
                        Ones_Count_Inc  = Correlated_Bit;
                        Zeros_Count_Inc = !Correlated_Bit;
                        if (last_chip) begin
                            chip_cnt_next = '0;
                            state_next    = WRITE;
                        end else begin
                            chip_cnt_next = chip_cnt + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    STP_Out_Reg_Load     = 1'b1;
                    STP_Out_Reg_Addr     = bit_idx;
                    Ones_Zeros_Count_Clr = 1'b1;
                    if (bit_idx == last_bit(sf)) begin
                        state_next = DONE;
                    end else begin
                        bit_idx_next  = bit_idx + 5'd1;
                        chip_cnt_next = '0;
                        state_next    = REF;
                    end
                end
                DONE: begin
                    STP_Out_Reg_Re = 1'b1;
                    Out_Valid      = 1'b1;
                    if (Out_Ack) begin
                        bit_idx_next = '0;
                        state_next   = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demod_ctrl.sv
// Self-checking bench for demod_ctrl: a chip-index frame model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_demod_ctrl;

    logic       Clk            = 1'b0;
    logic       N_Rst          = 1'b1;
    logic       Valid_Data     = 1'b0;
    logic       Correlated_Bit = 1'b0;
    logic [4:0] Spread_Factor  = 5'd0;
    logic       Out_Ack        = 1'b0;
    logic       Frame_Abort    = 1'b0;
    logic       Chip_Ready;
    logic [3:0] Var_Del_Reg_Addr;
    logic       Var_Del_Reg_Load;
    logic       Var_Del_Reg_Re;
    logic       Ones_Count_Inc;
    logic       Zeros_Count_Inc;
    logic       Ones_Zeros_Count_Clr;
    logic       STP_Out_Reg_Load;
    logic [4:0] STP_Out_Reg_Addr;
    logic       STP_Out_Reg_Re;
    logic       Out_Valid;

    int total = 0;
    int bad   = 0;

    demod_ctrl dut (
        .Clk                 (Clk),
        .N_Rst               (N_Rst),
        .Valid_Data          (Valid_Data),
        .Correlated_Bit      (Correlated_Bit),
        .Spread_Factor       (Spread_Factor),
        .Out_Ack             (Out_Ack),
        .Frame_Abort         (Frame_Abort),
        .Chip_Ready          (Chip_Ready),
        .Var_Del_Reg_Addr    (Var_Del_Reg_Addr),
        .Var_Del_Reg_Load    (Var_Del_Reg_Load),
        .Var_Del_Reg_Re      (Var_Del_Reg_Re),
        .Ones_Count_Inc      (Ones_Count_Inc),
        .Zeros_Count_Inc     (Zeros_Count_Inc),
        .Ones_Zeros_Count_Clr(Ones_Zeros_Count_Clr),
        .STP_Out_Reg_Load    (STP_Out_Reg_Load),
        .STP_Out_Reg_Addr    (STP_Out_Reg_Addr),
        .STP_Out_Reg_Re      (STP_Out_Reg_Re),
        .Out_Valid           (Out_Valid)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int decodeSf(input int v);
        return (v == 2 || v == 4 || v == 8 || v == 16) ? v : 16;
    endfunction

    // Frame model: a frame is 64 accepted chips; each bit spans 2*sf chips
    // (sf reference then sf data), followed by one write cycle per bit.
    int m_chips = 0;
    int m_mode  = 0;
    int m_sf    = 16;
    int m_snow;
    int e_within;
    int e_ready, e_vaddr, e_vload, e_vre, e_ones, e_zeros, e_clr;
    int e_sload, e_saddr, e_sre, e_ovalid;

    always_comb begin
        e_ready = 0; e_vaddr = 0; e_vload = 0; e_vre = 0; e_ones = 0; e_zeros = 0;
        e_clr = 0; e_sload = 0; e_saddr = 0; e_sre = 0; e_ovalid = 0; e_within = 0;
        m_snow = (m_chips == 0) ? decodeSf(int'(Spread_Factor)) : m_sf;
        if (Frame_Abort) begin
            e_clr = 1;
        end else if (m_mode == 0) begin
            e_ready  = 1;
            e_within = m_chips % (2 * m_sf);
            if (e_within < m_sf) begin
                e_vaddr = e_within;
                e_vload = int'(Valid_Data);
            end else begin
                e_vre   = 1;
                e_vaddr = e_within - m_sf;
                e_ones  = int'(Valid_Data && Correlated_Bit);
                e_zeros = int'(Valid_Data && !Correlated_Bit);
            end
        end else if (m_mode == 1) begin
            e_sload = 1;
            e_clr   = 1;
            e_saddr = m_chips / (2 * m_sf) - 1;
        end else begin
            e_sre    = 1;
            e_ovalid = 1;
        end
    end

    always @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            m_chips <= 0;
            m_mode  <= 0;
            m_sf    <= 16;
        end else if (Frame_Abort) begin
            m_chips <= 0;
            m_mode  <= 0;
        end else if (m_mode == 0) begin
            if (Valid_Data) begin
                m_sf    <= m_snow;
                m_chips <= m_chips + 1;
                if ((m_chips + 1) % (2 * m_snow) == 0) m_mode <= 1;
            end
        end else if (m_mode == 1) begin
            m_mode <= (m_chips == 64) ? 2 : 0;
        end else if (Out_Ack) begin
            m_chips <= 0;
            m_mode  <= 0;
        end
    end

    always @(negedge Clk) begin
        checkOutput("Chip_Ready", int'(Chip_Ready), e_ready);
        checkOutput("Var_Del_Reg_Addr", int'(Var_Del_Reg_Addr), e_vaddr);
        checkOutput("Var_Del_Reg_Load", int'(Var_Del_Reg_Load), e_vload);
        checkOutput("Var_Del_Reg_Re", int'(Var_Del_Reg_Re), e_vre);
        checkOutput("Ones_Count_Inc", int'(Ones_Count_Inc), e_ones);
        checkOutput("Zeros_Count_Inc", int'(Zeros_Count_Inc), e_zeros);
        checkOutput("Ones_Zeros_Count_Clr", int'(Ones_Zeros_Count_Clr), e_clr);
        checkOutput("STP_Out_Reg_Load", int'(STP_Out_Reg_Load), e_sload);
        checkOutput("STP_Out_Reg_Addr", int'(STP_Out_Reg_Addr), e_saddr);
        checkOutput("STP_Out_Reg_Re", int'(STP_Out_Reg_Re), e_sre);
        checkOutput("Out_Valid", int'(Out_Valid), e_ovalid);
    end

    // Stand-in datapath: counters and output register driven by DUT pulses.
    int          ones_acc, zeros_acc, stp_loads;
    logic [31:0] stp_data, stp_written;

    always @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            ones_acc    <= 0;
            zeros_acc   <= 0;
            stp_loads   <= 0;
            stp_data    <= '0;
            stp_written <= '0;
        end else begin
            if (STP_Out_Reg_Load) begin
                stp_data[STP_Out_Reg_Addr]    <= (ones_acc > zeros_acc);
                stp_written[STP_Out_Reg_Addr] <= 1'b1;
                stp_loads                     <= stp_loads + 1;
            end
            if (Ones_Zeros_Count_Clr) begin
                ones_acc  <= 0;
                zeros_acc <= 0;
            end else begin
                ones_acc  <= ones_acc + int'(Ones_Count_Inc);
                zeros_acc <= zeros_acc + int'(Zeros_Count_Inc);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic c, input logic [4:0] s,
                                 input logic ack, input logic ab);
        @(posedge Clk);
        #1;
        Valid_Data     = v;
        Correlated_Bit = c;
        Spread_Factor  = s;
        Out_Ack        = ack;
        Frame_Abort    = ab;
    endtask

    task automatic doReset();
        @(posedge Clk);
        #3;
        Valid_Data = 1'b0; Correlated_Bit = 1'b0; Spread_Factor = 5'd0;
        Out_Ack = 1'b0; Frame_Abort = 1'b0;
        N_Rst = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        N_Rst = 1'b1;
    endtask

    // Back-to-back frame: Spread_Factor is only meaningful on the first chip,
    // afterwards it is scrambled; Out_Ack pulses mid-bit must be ignored.
    task automatic runFrame(input logic [4:0] sf_drive, input int sched,
                            input logic [15:0] bits, input logic wv);
        for (int b = 0; b < 32 / sched; b++) begin
            for (int i = 0; i < sched; i++)
                applyStimulus(1'b1, 1'b0, (b == 0 && i == 0) ? sf_drive : 5'd3, (i == 1), 1'b0);
            for (int i = 0; i < sched; i++)
                applyStimulus(1'b1, bits[b], 5'd3, 1'b0, 1'b0);
            applyStimulus(wv, 1'b1, 5'd3, 1'b0, 1'b0);
            @(negedge Clk);
            checkOutput("write_ready", int'(Chip_Ready), 0);
            checkOutput("write_counts", ones_acc + zeros_acc, sched);
        end
    endtask

    initial begin
        #1 N_Rst = 1'b0;
        #20 N_Rst = 1'b1;
        @(negedge Clk);
        checkOutput("reset_ready", int'(Chip_Ready), 1);
        checkOutput("reset_valid", int'(Out_Valid), 0);

        // sf=4, ref 1010 / data 1010: every data chip correlates.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, (i == 0) ? 5'd4 : 5'd9, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("c9_stp_load", int'(STP_Out_Reg_Load), 1);
        checkOutput("c9_stp_addr", int'(STP_Out_Reg_Addr), 0);
        checkOutput("c9_ones", ones_acc, 4);
        checkOutput("c9_zeros", zeros_acc, 0);
        applyStimulus(1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("bit0_value", int'(stp_data[0]), 1);
        checkOutput("bit0_written", int'(stp_written[0]), 1);
        applyStimulus(1'b0, 1'b0, 5'd9, 1'b0, 1'b1);

        // sf=2 full frame, data chips inverted against reference.
        doReset();
        runFrame(5'd2, 2, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("sf2_out_valid", int'(Out_Valid), 1);
        checkOutput("sf2_loads", stp_loads, 16);
        checkOutput("sf2_written", int'(stp_written[15:0]), 16'hFFFF);
        checkOutput("sf2_data", int'(stp_data[15:0]), 0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("sf2_idle_valid", int'(Out_Valid), 0);

        // sf=16 with chips offered during WRITE, then a long wait in DONE.
        doReset();
        runFrame(5'd16, 16, 16'h0002, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
            @(negedge Clk);
            checkOutput("done_hold_valid", int'(Out_Valid), 1);
            checkOutput("done_hold_ready", int'(Chip_Ready), 0);
        end
        checkOutput("sf16_data", int'(stp_data[1:0]), 2);
        applyStimulus(1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd4, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("ack_idle_valid", int'(Out_Valid), 0);
        checkOutput("ack_idle_ready", int'(Chip_Ready), 1);

        // sf=8, abort on the fourth data chip of bit 0.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, (i == 0) ? 5'd8 : 5'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd2, 1'b0, 1'b1);
        @(negedge Clk);
        checkOutput("abort_clr", int'(Ones_Zeros_Count_Clr), 1);
        checkOutput("abort_ready", int'(Chip_Ready), 0);
        checkOutput("abort_ones", int'(Ones_Count_Inc), 0);
        applyStimulus(1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("post_abort_ready", int'(Chip_Ready), 1);
        checkOutput("post_abort_re", int'(Var_Del_Reg_Re), 0);
        runFrame(5'd8, 8, 16'h0006, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        checkOutput("sf8_data", int'(stp_data[3:0]), 6);
        checkOutput("sf8_loads", stp_loads, 4);

        // An unsupported spread factor behaves as 16.
        doReset();
        runFrame(5'd5, 16, 16'h0001, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("bad_sf_valid", int'(Out_Valid), 1);
        checkOutput("bad_sf_data", int'(stp_data[1:0]), 1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of REF.
        doReset();
        applyStimulus(1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
        @(posedge Clk);
        #3;
        Valid_Data = 1'b0;
        N_Rst      = 1'b0;
        #1;
        checkOutput("async_ready", int'(Chip_Ready), 1);
        checkOutput("async_addr", int'(Var_Del_Reg_Addr), 0);
        checkOutput("async_load", int'(Var_Del_Reg_Load), 0);
        checkOutput("async_valid", int'(Out_Valid), 0);
        @(posedge Clk);
        #1;
        N_Rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
